// File: rtl/ppu_mixed_dpram.sv
// Mixed-width dual-port RAM for PPU sprite/attribute tables.
// Port A is a wide word port with per-slice write mask. Port B is a narrow
// slice port. A clear engine fills every word with CLEAR_VALUE after reset
// or on request. Port B wins same-slice write collisions.
module ppu_mixed_dpram #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned B_WIDTH = 2,
  parameter int unsigned A_DEPTH = 32,
  localparam int unsigned R = A_WIDTH / B_WIDTH,
  parameter bit RDW_NEW = 1'b0,
  parameter bit OUT_REG = 1'b0,
  parameter logic [A_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [$clog2(A_DEPTH)-1:0]     address_a,
  input  logic [A_WIDTH-1:0]             data_a,
  input  logic                           wren_a,
  input  logic [R-1:0]                   wmask_a,
  output logic [A_WIDTH-1:0]             q_a,
  input  logic [$clog2(A_DEPTH*R)-1:0]   address_b,
  input  logic [B_WIDTH-1:0]             data_b,
  input  logic                           wren_b,
  output logic [B_WIDTH-1:0]             q_b,
  input  logic                           clear_req,
  output logic                           busy
);

  localparam int unsigned AW  = $clog2(A_DEPTH);
  localparam int unsigned BAW = $clog2(A_DEPTH * R);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;

  logic [B_WIDTH-1:0] mem [A_DEPTH*R];
  logic [BAW-1:0]     a_idx [R];
  logic [AW-1:0]      word_sel;
  logic               rd_en;

  logic [A_WIDTH-1:0] rd_a;
  logic [B_WIDTH-1:0] rd_b;
  logic [B_WIDTH-1:0] a_slc;

  logic [A_WIDTH-1:0] qa1, qa2;
  logic [B_WIDTH-1:0] qb1, qb2;

  assign busy     = (state_q == CLEAR);
  assign rd_en    = ~busy & ~clear_req;
  // The clear sweep borrows the port-A word path, so one index table serves both.
  assign word_sel = busy ? cnt_q : address_a;

  // Slice addresses of the word currently on the port-A path
  always_comb begin
    for (int unsigned i = 0; i < R; i++) begin
      a_idx[i] = BAW'(word_sel) * BAW'(R) + BAW'(i);
    end
  end

  // Clear-engine state register and word counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear-engine next state: one word per cycle, request ignored mid-sweep
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(A_DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Array writes: clear sweep, else masked port-A then port-B
  always_ff @(posedge clock) begin
    if (busy) begin
      for (int unsigned i = 0; i < R; i++) begin
        mem[a_idx[i]] <= CLEAR_VALUE[i*B_WIDTH +: B_WIDTH];
      end
    end else begin
      if (wren_a) begin
        for (int unsigned i = 0; i < R; i++) begin
          if (wmask_a[i]) mem[a_idx[i]] <= data_a[i*B_WIDTH +: B_WIDTH];
        end
      end
      // Issued after port A so that the later assignment wins a shared slice.
      if (wren_b) mem[address_b] <= data_b;
    end
  end

  // Read data, optionally forwarding this edge's writes (port B priority)
  always_comb begin
    rd_a  = '0;
    a_slc = '0;
    for (int unsigned i = 0; i < R; i++) begin
      a_slc = mem[a_idx[i]];
      if (RDW_NEW) begin
        if (wren_a && wmask_a[i])            a_slc = data_a[i*B_WIDTH +: B_WIDTH];
        if (wren_b && address_b == a_idx[i]) a_slc = data_b;
      end
      rd_a[i*B_WIDTH +: B_WIDTH] = a_slc;
    end
    rd_b = mem[address_b];
    if (RDW_NEW) begin
      for (int unsigned i = 0; i < R; i++) begin
        if (wren_a && wmask_a[i] && a_idx[i] == address_b) rd_b = data_a[i*B_WIDTH +: B_WIDTH];
      end
      if (wren_b) rd_b = data_b;
    end
  end

  // Output registers; both stages forced to zero while clearing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      qa1 <= '0;
      qa2 <= '0;
      qb1 <= '0;
      qb2 <= '0;
    end else if (rd_en) begin
      qa1 <= rd_a;
      qb1 <= rd_b;
      qa2 <= qa1;
      qb2 <= qb1;
    end else begin
      qa1 <= '0;
      qa2 <= '0;
      qb1 <= '0;
      qb2 <= '0;
    end
  end

  assign q_a = OUT_REG ? qa2 : qa1;
  assign q_b = OUT_REG ? qb2 : qb1;

endmodule

// File: tb/tb_ppu_mixed_dpram.sv
// Bench for ppu_mixed_dpram: three instances (default; new-data RDW;
// new-data RDW with output register and non-zero clear value) share one
// stimulus stream and are checked every cycle against a word-level model,
// plus literal expectations for the directed scenarios.
module tb_ppu_mixed_dpram;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [4:0] address_a = '0;
  logic [7:0] data_a = '0;
  logic       wren_a = 1'b0;
  logic [3:0] wmask_a = '0;
  logic [6:0] address_b = '0;
  logic [1:0] data_b = '0;
  logic       wren_b = 1'b0;
  logic       clear_req = 1'b0;

  logic [7:0] q_a_x [3];
  logic [1:0] q_b_x [3];
  logic       busy_x [3];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  ppu_mixed_dpram d0 (
    .clock(clock), .reset_n(reset_n),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .wmask_a(wmask_a), .q_a(q_a_x[0]),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b_x[0]),
    .clear_req(clear_req), .busy(busy_x[0])
  );

  ppu_mixed_dpram #(.RDW_NEW(1'b1)) d1 (
    .clock(clock), .reset_n(reset_n),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .wmask_a(wmask_a), .q_a(q_a_x[1]),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b_x[1]),
    .clear_req(clear_req), .busy(busy_x[1])
  );

  ppu_mixed_dpram #(.RDW_NEW(1'b1), .OUT_REG(1'b1), .CLEAR_VALUE(8'h3C)) d2 (
    .clock(clock), .reset_n(reset_n),
    .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .wmask_a(wmask_a), .q_a(q_a_x[2]),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b_x[2]),
    .clear_req(clear_req), .busy(busy_x[2])
  );

  // ---------------- model ----------------
  bit [7:0] mm [3][32];
  bit       busy_m [3];
  int       cnt_m [3];
  bit [7:0] qa1_m [3], qa2_m [3];
  bit [1:0] qb1_m [3], qb2_m [3];

  function automatic bit rdw_of(int k);
    return k != 0;
  endfunction
  function automatic bit oreg_of(int k);
    return k == 2;
  endfunction
  function automatic bit [7:0] cv_of(int k);
    return (k == 2) ? 8'h3C : 8'h00;
  endfunction
  function automatic bit [1:0] get_s(bit [7:0] w, int s);
    return 2'((w >> (2 * s)) & 8'h03);
  endfunction
  function automatic bit [7:0] put_s(bit [7:0] w, int s, bit [1:0] v);
    bit [7:0] r;
    r = w;
    r[2*s +: 2] = v;
    return r;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      busy_m[k] = 1'b1;
      cnt_m[k]  = 0;
      qa1_m[k] = '0; qa2_m[k] = '0;
      qb1_m[k] = '0; qb2_m[k] = '0;
    end
  endtask

  initial reset_model();
  always @(negedge reset_n) reset_model();

  always @(posedge clock) begin
    if (!reset_n) begin
      reset_model();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (busy_m[k]) begin
          mm[k][cnt_m[k]] = cv_of(k);
          cnt_m[k]++;
          if (cnt_m[k] == 32) begin
            busy_m[k] = 1'b0;
            cnt_m[k]  = 0;
          end
          qa1_m[k] = '0; qa2_m[k] = '0;
          qb1_m[k] = '0; qb2_m[k] = '0;
        end else begin
          bit [7:0] old_w, new_w, ra;
          bit [1:0] old_s, new_s, rb;
          int bw, bs;
          bw = int'(address_b) / 4;
          bs = int'(address_b) % 4;
          old_w = mm[k][address_a];
          old_s = get_s(mm[k][bw], bs);
          if (wren_a)
            for (int i = 0; i < 4; i++)
              if (wmask_a[i]) mm[k][address_a] = put_s(mm[k][address_a], i, data_a[2*i +: 2]);
          if (wren_b) mm[k][bw] = put_s(mm[k][bw], bs, data_b);
          new_w = mm[k][address_a];
          new_s = get_s(mm[k][bw], bs);
          ra = rdw_of(k) ? new_w : old_w;
          rb = rdw_of(k) ? new_s : old_s;
          if (clear_req) begin
            busy_m[k] = 1'b1;
            cnt_m[k]  = 0;
            qa1_m[k] = '0; qa2_m[k] = '0;
            qb1_m[k] = '0; qb2_m[k] = '0;
          end else begin
            qa2_m[k] = qa1_m[k]; qa1_m[k] = ra;
            qb2_m[k] = qb1_m[k]; qb1_m[k] = rb;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("d%0d.busy", k), 32'(busy_x[k]), 32'(busy_m[k]));
        check($sformatf("d%0d.q_a", k), 32'(q_a_x[k]), 32'(oreg_of(k) ? qa2_m[k] : qa1_m[k]));
        check($sformatf("d%0d.q_b", k), 32'(q_b_x[k]), 32'(oreg_of(k) ? qb2_m[k] : qb1_m[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    wren_a = 1'b0; wren_b = 1'b0; wmask_a = '0; clear_req = 1'b0;
  endtask

  task automatic op(input logic [4:0] aa, input logic [7:0] da, input logic wa, input logic [3:0] ma,
                    input logic [6:0] ab, input logic [1:0] db, input logic wb);
    address_a = aa; data_a = da; wren_a = wa; wmask_a = ma;
    address_b = ab; data_b = db; wren_b = wb;
    step();
    idle_in();
  endtask

  // Counts edges until busy drops; optionally drives dropped writes and a mid-sweep request.
  task automatic sweep_count(input bit poke, output int n);
    n = 0;
    while (busy_x[0] && n < 100) begin
      if (poke) begin
        address_a = 5'(n); data_a = 8'h77; wren_a = 1'b1; wmask_a = 4'hF;
        address_b = 7'(n); data_b = 2'b01; wren_b = 1'b1;
        clear_req = (n == 3);
      end
      step();
      n++;
    end
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    idle_in();
    #2 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;

    // 1: reset state, sweep length, everything reads zero
    check("rst.busy", 32'(busy_x[0]), 32'd1);
    check("rst.q_a", 32'(q_a_x[0]), 32'h0);
    check("rst.q_b", 32'(q_b_x[0]), 32'h0);
    sweep_count(1'b0, n);
    check("sweep.len", 32'(n), 32'd32);
    for (int w = 0; w < 32; w++) begin
      op(5'(w), 8'h00, 1'b0, 4'h0, 7'h0, 2'b00, 1'b0);
      check("init.q_a", 32'(q_a_x[0]), 32'h00);
    end
    for (int s = 0; s < 128; s++) begin
      op(5'h0, 8'h00, 1'b0, 4'h0, 7'(s), 2'b00, 1'b0);
      check("init.q_b", 32'(q_b_x[0]), 32'h0);
    end

    // 2: wide write, narrow reads, narrow write, wide read
    op(5'd5, 8'hE4, 1'b1, 4'hF, 7'd0, 2'b00, 1'b0);
    for (int s = 20; s < 24; s++) begin
      op(5'd5, 8'h00, 1'b0, 4'h0, 7'(s), 2'b00, 1'b0);
      check("t2.q_b", 32'(q_b_x[0]), 32'(s - 20));
    end
    op(5'd5, 8'h00, 1'b0, 4'h0, 7'd21, 2'b11, 1'b1);
    op(5'd5, 8'h00, 1'b0, 4'h0, 7'd21, 2'b00, 1'b0);
    check("t2.q_a", 32'(q_a_x[0]), 32'hEC);

    // 3: masked write
    op(5'd3, 8'hFF, 1'b1, 4'b0101, 7'd0, 2'b00, 1'b0);
    op(5'd3, 8'h00, 1'b0, 4'h0, 7'd0, 2'b00, 1'b0);
    check("t3.q_a", 32'(q_a_x[0]), 32'h33);

    // 4: same-slice collision, port B wins; RDW old vs new on the same edge
    op(5'd2, 8'h00, 1'b1, 4'hF, 7'd9, 2'b10, 1'b1);
    check("t4.rdw_old", 32'(q_a_x[0]), 32'h00);
    check("t4.rdw_new", 32'(q_a_x[1]), 32'h08);
    op(5'd2, 8'h00, 1'b0, 4'h0, 7'd9, 2'b00, 1'b0);
    check("t4.q_a", 32'(q_a_x[0]), 32'h08);

    // 5: read-during-write on word 7, same-port and cross-port, with latency
    op(5'd7, 8'h00, 1'b0, 4'h0, 7'd29, 2'b00, 1'b0);
    op(5'd7, 8'h5A, 1'b1, 4'hF, 7'd29, 2'b00, 1'b0);
    check("t5.old.q_a", 32'(q_a_x[0]), 32'h00);
    check("t5.old.q_b", 32'(q_b_x[0]), 32'h0);
    check("t5.new.q_a", 32'(q_a_x[1]), 32'h5A);
    check("t5.new.q_b", 32'(q_b_x[1]), 32'h2);
    check("t5.oreg.q_a", 32'(q_a_x[2]), 32'h3C);
    check("t5.oreg.q_b", 32'(q_b_x[2]), 32'h3);
    op(5'd7, 8'h00, 1'b0, 4'h0, 7'd29, 2'b00, 1'b0);
    check("t5.old.next", 32'(q_a_x[0]), 32'h5A);
    check("t5.oreg.next", 32'(q_a_x[2]), 32'h5A);
    check("t5.oreg.q_b.next", 32'(q_b_x[2]), 32'h2);

    // 6: fill, clear request, reset mid-sweep, writes dropped while busy
    for (int w = 0; w < 32; w++) op(5'(w), 8'hAA, 1'b1, 4'hF, 7'd0, 2'b00, 1'b0);
    op(5'd0, 8'h00, 1'b0, 4'h0, 7'd0, 2'b00, 1'b0);
    check("t6.fill", 32'(q_a_x[0]), 32'hAA);
    address_a = 5'd0; data_a = 8'h00; wren_a = 1'b0;
    clear_req = 1'b1;
    step();
    idle_in();
    check("t6.busy", 32'(busy_x[0]), 32'd1);
    for (int c = 0; c < 9; c++) begin
      address_a = 5'(c); data_a = 8'h55; wren_a = 1'b1; wmask_a = 4'hF;
      step();
    end
    idle_in();
    reset_n = 1'b0;
    step();
    check("t6.rst.busy", 32'(busy_x[0]), 32'd1);
    reset_n = 1'b1;
    sweep_count(1'b1, n);
    check("t6.sweep.len", 32'(n), 32'd32);
    for (int w = 0; w < 32; w++) begin
      op(5'(w), 8'h00, 1'b0, 4'h0, 7'(4 * w + 3), 2'b00, 1'b0);
      check("t6.q_a", 32'(q_a_x[0]), 32'h00);
    end
    step();
    check("t6.oreg.q_a", 32'(q_a_x[2]), 32'h3C);
    check("t6.oreg.q_b", 32'(q_b_x[2]), 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_mixed_dpram.md
# ppu_mixed_dpram

Parametrised mixed-width dual-port RAM for PPU sprite/attribute tables. Port A is a wide CPU-side word port. Port B is a narrow slice port used by sprite evaluation. It extends the fixed 32×8 / 2-bit HOAM arrangement with configurable widths and depth, per-slice write masking on port A, defined collision and read-during-write behaviour, an optional output pipeline stage, and a built-in clear engine that runs after reset or on request.

## Interface
Parameters:
- `A_WIDTH`, 8: port A word width. Must be a multiple of `B_WIDTH`.
- `B_WIDTH`, 2: port B slice width.
- `A_DEPTH`, 32: number of port-A words. Must be a power of two.
- `R`, derived as `A_WIDTH/B_WIDTH`: slices per word. Must be a power of two.
- `RDW_NEW`, 0: read-during-write mode. 0 returns the old data; 1 returns the new data.
- `OUT_REG`, 0: adds an extra output register stage when 1.
- `CLEAR_VALUE`, 0: the `A_WIDTH` fill pattern written by the clear engine.

Ports:
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `address_a`, in, log2(`A_DEPTH`): port A word address.
- `data_a`, in, `A_WIDTH`: port A write data.
- `wren_a`, in, 1: port A write enable.
- `wmask_a`, in, `R`: port A per-slice write mask. Bit i enables slice i, which is bits [i*`B_WIDTH` +: `B_WIDTH`].
- `q_a`, out, `A_WIDTH`: port A read data.
- `address_b`, in, log2(`A_DEPTH`*`R`): port B slice address. Slice = `address_b[log2 R-1:0]`; word = the upper bits.
- `data_b`, in, `B_WIDTH`: port B write data.
- `wren_b`, in, 1: port B write enable.
- `q_b`, out, `B_WIDTH`: port B read data.
- `clear_req`, in, 1: single-cycle pulse that starts a clear sweep.
- `busy`, out, 1: high while the clear engine runs.

## Operation
- Storage: `A_DEPTH`*`R` slices of `B_WIDTH` bits.
  - Port A word w, slice i, maps to port B address w*`R`+i.
- Port A read: returns the full word at `address_a`. Write: updates only the slices whose `wmask_a` bit is set.
- Port B read/write: accesses the single slice at `address_b`.
- Write collision: if both ports write the same slice in the same cycle, port B's data is stored. Port A's non-colliding slices are still written.
- Read-during-write, same port or cross-port, same cycle and same slice:
  - `RDW_NEW=0`: the read returns the pre-edge contents.
  - `RDW_NEW=1`: the read returns the value stored at that edge, after the collision rule is applied.
- Clear FSM, states IDLE and CLEAR:
  - Reset enters CLEAR with the word counter at 0.
  - CLEAR writes `CLEAR_VALUE` to one word per cycle. After word `A_DEPTH`-1 it goes to IDLE.
  - In IDLE, a `clear_req` pulse enters CLEAR with the counter at 0.
  - `clear_req` received while in CLEAR is ignored.
  - While in CLEAR: `wren_a` and `wren_b` are ignored, reads are not performed, and `q_a`/`q_b` hold 0.
- Reset asserted mid-sweep: the counter goes to 0 asynchronously and the sweep restarts after release.

## Timing
- Reset values: `q_a`=0, `q_b`=0, `busy`=1, FSM=CLEAR, counter=0, pipeline registers=0. Array contents are undefined until the sweep completes.
- Clear duration: `busy` stays high for exactly `A_DEPTH` cycles after reset release or after the `clear_req` edge. It falls on the edge that writes the last word.
- The first access is accepted on the first edge where `busy` was sampled low.
- Read latency with `OUT_REG=0`: the address is sampled at edge N and `q` is valid after edge N.
- Read latency with `OUT_REG=1`: `q` is valid after edge N+1.
- A write at edge N is visible to any read sampled at edge N+1 or later.
- No handshake: one access per port per cycle, always accepted when `busy`=0.
- Address arithmetic: a port-B address wraps modulo `A_DEPTH`*`R`. An out-of-range port-A address is impossible by its width.

## Test plan
All scenarios use defaults except where a parameter is named.
1. Reset, then hold `reset_n` high: `busy`=1 for 32 cycles, then 0. Read all A words, then all B slices: each reads 0x00, then 2'b00.
2. Port A writes 0xE4 to word 5 with mask 4'hF. Port B then reads addresses 20..23: 0, 1, 2, 3 in order. Port B writes 2'b11 to address 21. Port A reads word 5: 0xEC.
3. Port A writes 0xFF to word 3 with mask 4'b0101, then reads it: 0x33.
4. Same cycle: port A writes 0x00 to word 2 with mask 4'hF, and port B writes 2'b10 to address 9. Port A reads word 2: 0x08.
5. Read-during-write with port A writing 0x5A to word 7 (old value 0x00) while port A reads word 7:
   - `RDW_NEW=0`: `q_a`=0x00, and 0x5A on the next read.
   - `RDW_NEW=1`: `q_a`=0x5A.
   - Repeat with `OUT_REG=1` and check the extra cycle of latency.
6. Fill memory with 0xAA, then pulse `clear_req`, then assert `reset_n` low at sweep cycle 10 and release it. `busy` stays high for 32 further cycles. Writes issued during `busy` are dropped. Every word reads `CLEAR_VALUE` afterward.
